// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver control points, data width and FIFO status
// layout reused by the RX/TX FIFOs and the register block.
package uart_pkg;

    localparam int UART_WIDTH = 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef struct packed {
        logic baud_clr;
        logic bit_cnt_clr;
        logic shift_en;
        logic rx_valid;
    } controlPoints_t;

    typedef struct packed {
        logic full;
        logic empty;
        logic level_irq;
        logic overrun;
    } fifo_status_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read so the FIFO
// can present its head entry with no read latency. Contents are never reset.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: first-word-fall-through read
// handshake, occupancy count, watermark interrupt and sticky overrun.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = UART_WIDTH,
    parameter int THRESH = 8
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [WIDTH-1:0]           i_rx_data,
    input  logic                       i_rx_valid,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_rd_valid,
    input  logic                       i_rd_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_level_irq,
    output logic                       o_overrun,
    input  logic                       i_clr_overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overrun;

    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    fifo_status_t  w_status;

    assign w_status.full      = (r_count == CW'(DEPTH));
    assign w_status.empty     = (r_count == '0);
    assign w_status.level_irq = (r_count >= CW'(THRESH));
    assign w_status.overrun   = r_overrun;

    // A pop frees the slot this same edge, so a full FIFO still accepts a push.
    assign w_pop  = !w_status.empty && i_rd_ready;
    assign w_push = i_rx_valid && (!w_status.full || w_pop);
    assign w_drop = i_rx_valid && !w_push;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
            if (w_drop)
                r_overrun <= 1'b1;
            else if (i_clr_overrun)
                r_overrun <= 1'b0;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .i_clock (i_clock),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_rx_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (o_rd_data)
    );

    assign o_count     = r_count;
    assign o_rd_valid  = !w_status.empty;
    assign o_full      = w_status.full;
    assign o_empty     = w_status.empty;
    assign o_level_irq = w_status.level_irq;
    assign o_overrun   = w_status.overrun;

endmodule
